// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_t;

  typedef enum logic [1:0] {
    PARITY_NONE     = 2'd0,
    PARITY_EVEN     = 2'd1,
    PARITY_ODD      = 2'd2,
    PARITY_NONE_ALT = 2'd3
  } parity_mode_t;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  // Out-of-range frame widths fall back to the widest supported frame.
  function automatic logic [3:0] sat_data_bits(input logic [3:0] req, input logic [3:0] max_bits);
    return (req < MIN_DATA_BITS || req > max_bits) ? max_bits : req;
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one-clock tick every i_div+1 clocks, restartable.
module uart_os_tick_gen (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_restart,
  input  logic [15:0] i_div,
  output logic        o_tick
);

  logic [15:0] r_cnt;

  assign o_tick = (r_cnt >= i_div);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module uart_rx_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PtrW + 1)'(Depth));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_multi.sv
// Configurable UART receiver: 16x oversampling, 3-sample majority vote, FWFT word FIFO
// carrying per-word parity/frame flags and a sticky overrun flag.
module uart_rx_multi
  import uart_pkg::*;
#(
  parameter int unsigned F_CLK      = 16_000_000,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_16mhz,
  input  logic                  rstn,
  input  logic [15:0]           baud_div,
  input  logic [3:0]            data_bits,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  input  logic                  serial_in,
  input  logic                  rd_en,
  input  logic                  clr_overrun,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  fifo_full,
  output logic                  overrun,
  output logic                  rx_start_pulse,
  output logic                  rx_done_pulse
);

  localparam logic [3:0]  MaxBits  = 4'(DATA_WIDTH);
  localparam logic [3:0]  LastTick = 4'(OVERSAMPLE - 1);
  localparam int unsigned FW       = DATA_WIDTH + 2;

  if (OVERSAMPLE != 16 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || F_CLK == 0) begin : g_bad_cfg
    $fatal(1, "uart_rx_multi: unsupported parameter set");
  end

  logic [1:0]            r_sync;
  logic                  r_rx_d;
  logic                  w_rx, w_fall, w_tick, w_maj;
  rx_state_t             r_state, w_state_nxt;
  logic [3:0]            r_os, w_os_nxt;
  logic [1:0]            r_samp, w_samp_nxt;
  logic [3:0]            r_bit_cnt, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_par_err, w_perr_nxt;
  logic                  r_frame_err, w_ferr_nxt;
  logic                  r_stop_cnt, w_stop_nxt;
  logic [15:0]           r_div;
  logic [3:0]            r_nbits;
  parity_mode_t          r_pmode;
  logic                  r_two_stop;
  logic                  w_latch, w_push, w_start_ok, w_par_en, w_last_bit;
  logic [FW-1:0]         w_wdata, w_head;
  logic                  w_empty, w_full, w_drop;
  logic                  r_overrun;

  assign w_rx       = r_sync[1];
  assign w_fall     = r_rx_d & ~w_rx;
  assign w_maj      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);
  assign w_par_en   = (r_pmode == PARITY_EVEN) || (r_pmode == PARITY_ODD);
  assign w_last_bit = (r_bit_cnt == r_nbits - 4'd1);
  assign w_wdata    = {w_ferr_nxt, r_par_err, r_shift};

  uart_os_tick_gen u_tick_gen (
    .i_clk     (clk_16mhz),
    .i_rstn    (rstn),
    .i_restart (w_latch),
    .i_div     (r_div),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) begin
      r_sync      <= 2'b11;
      r_rx_d      <= 1'b1;
      r_state     <= StIdle;
      r_os        <= '0;
      r_samp      <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_stop_cnt  <= 1'b0;
      r_div       <= '0;
      r_nbits     <= MaxBits;
      r_pmode     <= PARITY_NONE;
      r_two_stop  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], serial_in};
      r_rx_d      <= w_rx;
      r_state     <= w_state_nxt;
      r_os        <= w_os_nxt;
      r_samp      <= w_samp_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_par_err   <= w_perr_nxt;
      r_frame_err <= w_ferr_nxt;
      r_stop_cnt  <= w_stop_nxt;
      if (w_latch) begin
        r_div      <= baud_div;
        r_nbits    <= sat_data_bits(data_bits, MaxBits);
        r_pmode    <= parity_mode_t'(parity_mode);
        r_two_stop <= two_stop;
      end
      // A new drop outranks a simultaneous clear.
      if (w_drop) r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os;
    w_samp_nxt  = r_samp;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_par_err;
    w_ferr_nxt  = r_frame_err;
    w_stop_nxt  = r_stop_cnt;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_start_ok  = 1'b0;
    if (r_state == StIdle) begin
      if (w_fall) begin
        w_state_nxt = StStart;
        w_latch     = 1'b1;
        w_os_nxt    = '0;
        w_bit_nxt   = '0;
        w_shift_nxt = '0;
        w_perr_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_stop_nxt  = 1'b0;
      end
    end else if (r_state == StWaitIdle) begin
      if (w_rx) w_state_nxt = StIdle;
    end else if (w_tick) begin
      w_os_nxt = r_os + 4'd1;
      if (r_os == 4'd7) w_samp_nxt[0] = w_rx;
      if (r_os == 4'd8) w_samp_nxt[1] = w_rx;
      // Tick 9 completes the majority vote for the current bit.
      if (r_os == 4'd9) begin
        case (r_state)
          StStart: begin
            if (w_maj) w_state_nxt = StIdle;
            else w_start_ok = 1'b1;
          end
          StData:   w_shift_nxt = r_shift | (DATA_WIDTH'(w_maj) << r_bit_cnt);
          StParity: w_perr_nxt = (^r_shift) ^ w_maj ^ (r_pmode == PARITY_ODD);
          StStop: begin
            w_ferr_nxt = r_frame_err | ~w_maj;
            if (r_stop_cnt == r_two_stop) begin
              w_push      = 1'b1;
              w_state_nxt = w_rx ? StIdle : StWaitIdle;
            end
          end
          default: ;
        endcase
      end
      if (r_os == LastTick) begin
        case (r_state)
          StStart: w_state_nxt = StData;
          StData: begin
            if (w_last_bit) w_state_nxt = w_par_en ? StParity : StStop;
            else w_bit_nxt = r_bit_cnt + 4'd1;
          end
          StParity: w_state_nxt = StStop;
          StStop:   w_stop_nxt = 1'b1;
          default: ;
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .Width (FW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_16mhz),
    .i_rstn  (rstn),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (rd_en),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_drop  (w_drop)
  );

  assign data_out       = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign parity_error   = ~w_empty & w_head[DATA_WIDTH];
  assign frame_error    = ~w_empty & w_head[DATA_WIDTH+1];
  assign data_valid     = ~w_empty;
  assign fifo_full      = w_full;
  assign overrun        = r_overrun;
  assign rx_start_pulse = w_start_ok;
  assign rx_done_pulse  = w_push;

endmodule

// File: tb/tb_uart_rx_multi.sv
// Scoreboard bench for uart_rx_multi: stimulus queues expected words, a monitor pops and checks.
module tb_uart_rx_multi;
  import uart_pkg::*;

  localparam int DW       = 8;
  localparam int BIT_CLKS = 144;
  localparam logic [7:0] SWEEP [8] = '{8'hDB, 8'hB6, 8'h91, 8'h6D, 8'h48, 8'h24, 8'h12, 8'h01};
  localparam logic [7:0] BURST [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  logic          clk_16mhz = 1'b0;
  logic          rstn = 1'b0;
  logic [15:0]   baud_div = 16'd8;
  logic [3:0]    data_bits = 4'd8;
  logic [1:0]    parity_mode = 2'd0;
  logic          two_stop = 1'b0;
  logic          serial_in = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_overrun = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid, parity_error, frame_error, fifo_full, overrun;
  logic          rx_start_pulse, rx_done_pulse;

  int            vectors = 0;
  int            miscompares = 0;
  int            start_cnt = 0;
  int            done_cnt = 0;
  int            s0, d0;
  bit            rd_allow = 1'b1;
  logic [DW+1:0] exp_q [$];
  logic [DW+1:0] exp_w;

  always #31 clk_16mhz = ~clk_16mhz;

  uart_rx_multi #(
    .F_CLK      (16_000_000),
    .DATA_WIDTH (DW),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk_16mhz      (clk_16mhz),
    .rstn           (rstn),
    .baud_div       (baud_div),
    .data_bits      (data_bits),
    .parity_mode    (parity_mode),
    .two_stop       (two_stop),
    .serial_in      (serial_in),
    .rd_en          (rd_en),
    .clr_overrun    (clr_overrun),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .fifo_full      (fifo_full),
    .overrun        (overrun),
    .rx_start_pulse (rx_start_pulse),
    .rx_done_pulse  (rx_done_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_16mhz);
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    idle(BIT_CLKS);
  endtask

  // pmode: 0 none, 1 even, 2 odd. The line is left at stop_v afterwards.
  task automatic send_frame(input logic [8:0] d, input int nb, input int pmode, input bit flip,
                            input int nstop, input logic stop_v);
    logic p;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pmode != 0) begin
      p = 1'b0;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      if (pmode == 2) p = ~p;
      if (flip) p = ~p;
      drive_bit(p);
    end
    for (int i = 0; i < nstop; i++) drive_bit(stop_v);
  endtask

  task automatic expect_word(input logic ferr, input logic perr, input logic [7:0] d);
    exp_q.push_back({ferr, perr, d});
  endtask

  always @(negedge clk_16mhz) begin
    if (rx_start_pulse) start_cnt++;
    if (rx_done_pulse) done_cnt++;
  end

  // Monitor: owns rd_en, pops and checks the FIFO head whenever reading is allowed.
  initial begin
    forever begin
      @(negedge clk_16mhz);
      rd_en = 1'b0;
      if (rstn && rd_allow && data_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got 0x%0h, want no word",
                   {frame_error, parity_error, data_out});
        end else begin
          exp_w = exp_q.pop_front();
          chk("rx_word", 32'({frame_error, parity_error, data_out}), 32'(exp_w));
        end
        rd_en = 1'b1;
      end
    end
  end

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_parity_error", 32'(parity_error), 32'd0);
    chk("rst_frame_error", 32'(frame_error), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_pulses", 32'({rx_start_pulse, rx_done_pulse}), 32'd0);
    chk("rst_state", 32'(u_dut.r_state), 32'(StIdle));
    rstn = 1'b1;
    idle(20);

    // 8N1 sweep
    for (int i = 0; i < 8; i++) begin
      s0 = start_cnt;
      d0 = done_cnt;
      expect_word(1'b0, 1'b0, SWEEP[i]);
      send_frame(9'(SWEEP[i]), 8, 0, 1'b0, 1, 1'b1);
      idle(100);
      chk("sweep_start_pulses", 32'(start_cnt - s0), 32'd1);
      chk("sweep_done_pulses", 32'(done_cnt - d0), 32'd1);
    end

    // 7E2, good then flipped parity
    data_bits = 4'd7;
    parity_mode = 2'd1;
    two_stop = 1'b1;
    expect_word(1'b0, 1'b0, 8'h55);
    send_frame(9'h055, 7, 1, 1'b0, 2, 1'b1);
    idle(100);
    expect_word(1'b0, 1'b1, 8'h55);
    send_frame(9'h055, 7, 1, 1'b1, 2, 1'b1);
    idle(100);
    data_bits = 4'd8;
    parity_mode = 2'd0;
    two_stop = 1'b0;

    // Start-bit glitch
    s0 = start_cnt;
    serial_in = 1'b0;
    #1085;
    serial_in = 1'b1;
    idle(400);
    chk("glitch_no_start", 32'(start_cnt - s0), 32'd0);
    chk("glitch_fifo_empty", 32'(data_valid), 32'd0);
    expect_word(1'b0, 1'b0, 8'hA5);
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    idle(100);

    // Stop bit low followed by a break
    d0 = done_cnt;
    expect_word(1'b1, 1'b0, 8'h3C);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b0);
    idle(20 * BIT_CLKS);
    chk("break_state", 32'(u_dut.r_state), 32'(StWaitIdle));
    chk("break_one_word", 32'(done_cnt - d0), 32'd1);
    serial_in = 1'b1;
    idle(100);
    expect_word(1'b0, 1'b0, 8'h81);
    send_frame(9'h081, 8, 0, 1'b0, 1, 1'b1);
    idle(100);

    // Overrun with no reads
    rd_allow = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_word(1'b0, 1'b0, BURST[i]);
      send_frame(9'(BURST[i]), 8, 0, 1'b0, 1, 1'b1);
      idle(100);
    end
    chk("ovr_done_pulses", 32'(done_cnt - d0), 32'd5);
    chk("ovr_fifo_full", 32'(fifo_full), 32'd1);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    rd_allow = 1'b1;
    idle(20);
    chk("ovr_drained", 32'(data_valid), 32'd0);
    chk("ovr_not_full", 32'(fifo_full), 32'd0);

    // Reset in the middle of DATA with a word already buffered
    rd_allow = 1'b0;
    send_frame(9'h077, 8, 0, 1'b0, 1, 1'b1);
    idle(100);
    chk("pre_rst_valid", 32'(data_valid), 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("mid_state", 32'(u_dut.r_state), 32'(StData));
    rstn = 1'b0;
    serial_in = 1'b1;
    idle(1);
    chk("mrst_data_valid", 32'(data_valid), 32'd0);
    chk("mrst_data_out", 32'(data_out), 32'd0);
    chk("mrst_fifo_full", 32'(fifo_full), 32'd0);
    chk("mrst_state", 32'(u_dut.r_state), 32'(StIdle));
    rd_allow = 1'b1;
    idle(5);
    rstn = 1'b1;
    idle(50);
    expect_word(1'b0, 1'b0, 8'h42);
    send_frame(9'h042, 8, 0, 1'b0, 1, 1'b1);
    idle(100);

    chk("all_words_seen", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
